pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It compares register indices across stages and drives stall, flush and forwarding selects for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also runs a wait-state FSM that freezes the pipe while a data-memory access is outstanding.

## Interface
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before the access is abandoned. Must be at least 1.
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous reset, active-high. The name is kept for codebase consistency; the reset acts when rst_n=1.
- rR1_ID, rR2_ID  in  5 each  source register indices of the instruction in ID.
- re1_ID, re2_ID  in  1 each  the ID instruction actually reads rR1/rR2.
- rR1_EX, rR2_EX  in  5 each  source indices of the instruction in EX.
- wR_EX, RF_we_EX, WBsel_EX  in  5/1/2  EX destination, write enable, write-back select.
- wR_MEM, RF_we_MEM, WBsel_MEM  in  5/1/2  MEM destination, write enable, write-back select.
- wR_WB, RF_we_WB  in  5/1  WB destination and write enable.
- branch_taken_EX  in  1  branch or jump resolved taken in EX.
- Dram_req_MEM  in  1  MEM stage is accessing DRAM (load or store).
- Dram_ack  in  1  DRAM completes the access this cycle.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the register.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all control fields 0).
- fwdA_EX, fwdB_EX  out  2 each  EX operand select: 00 = ID/EX rD, 01 = c_MEM, 10 = pc4_MEM, 11 = WB write data.
- mem_wait  out  1  FSM is in MEM_WAIT.
- mem_err  out  1  sticky flag: an access hit the timeout.

## Operation
- WBsel encoding: 00 = ALU c, 01 = DRAM read, 10 = pc4.
- A match requires a nonzero index, an enabled read, an equal destination and RF_we=1. x0 never causes a hazard or a forward.
- FSM states:
  - RUN → MEM_WAIT when Dram_req_MEM=1 and Dram_ack=0.
  - MEM_WAIT → RUN on Dram_ack=1.
  - MEM_WAIT → RUN with mem_err←1 when the wait counter reaches MEM_TIMEOUT.
- Wait counter: $clog2(MEM_TIMEOUT+1) bits. It clears on every RUN cycle and increments each MEM_WAIT cycle.
- Memory stall applies in RUN with req&!ack, and in MEM_WAIT while ack=0 and the counter is below MEM_TIMEOUT.
  - Asserts pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_flush.
  - Takes priority over every other condition.
- Branch flush: branch_taken_EX with no memory stall asserts ifid_flush and idex_flush. It overrides any load-use or RAW stall, because the ID instruction is wrong-path.
- Load-use: WBsel_EX=01 with an ID source matching wR_EX asserts pc_stall, ifid_stall and idex_flush for exactly 1 cycle. The dependent instruction then forwards from WB.
- Forwarding for each EX operand:
  - A MEM match takes priority over a WB match.
  - MEM match with WBsel_MEM=00 selects 01; with WBsel_MEM=10 selects 10.
  - MEM match with WBsel_MEM=01 cannot occur, because load-use already stalled.
  - Otherwise a WB match selects 11; otherwise 00.
- mem_err is cleared only by reset.

## Timing
- While rst_n=1, all outputs are 0; at the following edge state=RUN, counter=0, mem_err=0. A reset during MEM_WAIT abandons the wait.
- Stall, flush and fwd outputs are combinational from the current state and inputs, with zero-cycle latency.
- Ack in the same cycle as req: no stall.
- Ack arriving k cycles after req: stall lasts k cycles, releases in the ack cycle, and mem_wait is high for k cycles.
- Timeout: the stall lasts MEM_TIMEOUT+1 cycles. mem_err rises the cycle after the last stall cycle.
- During MEM_WAIT, branch_taken_EX stays frozen and its flush fires in the release cycle.

## Configuration
- FORWARDING_EN defined: forwarding and load-use behave as described in Operation.
- FORWARDING_EN undefined:
  - fwdA_EX and fwdB_EX are tied to 00.
  - Any ID source matching the EX or MEM destination asserts pc_stall, ifid_stall and idex_flush until the match clears. The RF writes first in WB.
  - The load-use special case is subsumed by this rule.

## Test plan
- Forwarding (FORWARDING_EN defined):
  - add x3 then sub x4,x3,x1 → fwdA_EX=01 in sub's EX cycle.
  - jal x1 then use of x1 → fwdA_EX=10.
  - Dependency two instructions back → 11.
- Load-use: lw x5 in EX with rR2_ID=5, re2_ID=1 → one cycle of pc_stall, ifid_stall, idex_flush, then fwdB_EX=11.
- DRAM wait: req with ack after 3 cycles → 3 stall cycles with memwb_flush=1 and mem_wait=1; release in the ack cycle.
- Branch during load-use: branch_taken_EX=1 together with a load-use match → ifid_flush=idex_flush=1, pc_stall=0.
- Timeout and reset: MEM_TIMEOUT=4 with ack never asserted → 5 stall cycles, then mem_err=1 and RUN. A reset asserted mid-wait clears the state, counter and mem_err at the next edge.
- x0 and no-forwarding: x0 destination produces no hazard or forward. With FORWARDING_EN undefined, an add-then-use pair stalls 2 cycles.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard and stall controller for a 5-stage pipeline
//               (IF, ID, EX, MEM, WB). It compares register indices across
//               stages and drives the stall, flush and forwarding selects.
//               A wait-state FSM freezes the pipe while a DRAM access is
//               outstanding. An access that waits too long is abandoned and
//               sets a sticky error flag.
// Config      : `FORWARDING_EN -- when defined, EX operands are forwarded
//               from MEM/WB and only load-use stalls for one cycle.
//               When undefined, the fwd selects are 00. Any ID source that
//               matches an EX or MEM destination stalls until the match
//               clears.
// Ports       : clk, rst_n (synchronous, active-high despite the name)
//               rR1_ID/rR2_ID/re1_ID/re2_ID    ID source indices + read enables
//               rR1_EX/rR2_EX                  EX source indices
//               wR_*/RF_we_*/WBsel_*           EX/MEM/WB destination info
//               branch_taken_EX                taken branch/jump in EX
//               Dram_req_MEM/Dram_ack          DRAM handshake
//               pc/ifid/idex/exmem_stall       register holds
//               ifid/idex/memwb_flush          bubble inserts
//               fwdA_EX/fwdB_EX                EX operand selects
//               mem_wait/mem_err               FSM status, sticky timeout
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rR1_ID,
    input  logic [4:0] rR2_ID,
    input  logic       re1_ID,
    input  logic       re2_ID,
    input  logic [4:0] rR1_EX,
    input  logic [4:0] rR2_EX,
    input  logic [4:0] wR_EX,
    input  logic       RF_we_EX,
    input  logic [1:0] WBsel_EX,
    input  logic [4:0] wR_MEM,
    input  logic       RF_we_MEM,
    input  logic [1:0] WBsel_MEM,
    input  logic [4:0] wR_WB,
    input  logic       RF_we_WB,
    input  logic       branch_taken_EX,
    input  logic       Dram_req_MEM,
    input  logic       Dram_ack,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_stall,
    output logic       exmem_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       memwb_flush,
    output logic [1:0] fwdA_EX,
    output logic [1:0] fwdB_EX,
    output logic       mem_wait,
    output logic       mem_err
);

    localparam int         C_CW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [0:0] C_ST_RUN  = 1'b0;
    localparam logic [0:0] C_ST_WAIT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [C_CW-1:0] cnt_q, cnt_d;
    logic            mem_err_q, mem_err_d;

    // ------------------------------------------------------------------
    // Wait-state FSM. The exit on timeout is taken from the last counted
    // wait cycle. The stall then covers the request cycle plus
    // MEM_TIMEOUT wait cycles, and mem_err is visible right after.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            C_ST_RUN: begin
                cnt_d = '0;
                if (Dram_req_MEM && !Dram_ack) state_d = C_ST_WAIT;
            end
            C_ST_WAIT: begin
                cnt_d = cnt_q + C_CW'(1);
                if (Dram_ack) begin
                    state_d = C_ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == C_CW'(MEM_TIMEOUT - 1)) begin
                    state_d   = C_ST_RUN;
                    cnt_d     = '0;
                    mem_err_d = 1'b1;
                end
            end
            default: begin
                state_d = C_ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= C_ST_RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_mem_stall;
    logic w_br_flush;
    logic w_raw;
    logic w_hz_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_mem_stall = ((state_q == C_ST_RUN)  && Dram_req_MEM && !Dram_ack) ||
                         ((state_q == C_ST_WAIT) && !Dram_ack &&
                          (cnt_q < C_CW'(MEM_TIMEOUT)));

    // A taken branch makes the ID instruction wrong-path, so it wins over
    // any ID-side stall. It waits for the memory stall to release.
    assign w_br_flush = branch_taken_EX && !w_mem_stall;

    // An ID source matches an EX or MEM destination only if the index is
    // nonzero, the read is enabled and the writer has RF_we set.
    logic w_id1_ex, w_id2_ex, w_id1_mem, w_id2_mem;
    assign w_id1_ex  = re1_ID && (rR1_ID != 5'd0) && (rR1_ID == wR_EX)  && RF_we_EX;
    assign w_id2_ex  = re2_ID && (rR2_ID != 5'd0) && (rR2_ID == wR_EX)  && RF_we_EX;
    assign w_id1_mem = re1_ID && (rR1_ID != 5'd0) && (rR1_ID == wR_MEM) && RF_we_MEM;
    assign w_id2_mem = re2_ID && (rR2_ID != 5'd0) && (rR2_ID == wR_MEM) && RF_we_MEM;

`ifdef FORWARDING_EN
    // Only a load in EX cannot be forwarded in time. The dependent
    // instruction waits one cycle and then takes the value from WB.
    assign w_raw = (WBsel_EX == 2'b01) && (w_id1_ex || w_id2_ex);

    logic w_a_mem, w_b_mem, w_a_wb, w_b_wb;
    assign w_a_mem = (rR1_EX != 5'd0) && (rR1_EX == wR_MEM) && RF_we_MEM;
    assign w_b_mem = (rR2_EX != 5'd0) && (rR2_EX == wR_MEM) && RF_we_MEM;
    assign w_a_wb  = (rR1_EX != 5'd0) && (rR1_EX == wR_WB)  && RF_we_WB;
    assign w_b_wb  = (rR2_EX != 5'd0) && (rR2_EX == wR_WB)  && RF_we_WB;

    // MEM holds the younger result, so it takes priority over WB. A MEM
    // load (WBsel=01) cannot reach this point because load-use stalled it.
    function automatic logic [1:0] fwd_sel(input logic m_mem, input logic m_wb,
                                           input logic [1:0] wbsel);
        logic [1:0] sel;
        sel = 2'b00;
        if (m_mem) begin
            if (wbsel == 2'b00)      sel = 2'b01;
            else if (wbsel == 2'b10) sel = 2'b10;
        end else if (m_wb) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    assign w_fwd_a = fwd_sel(w_a_mem, w_a_wb, WBsel_MEM);
    assign w_fwd_b = fwd_sel(w_b_mem, w_b_wb, WBsel_MEM);
`else
    // Without forwarding, any pending EX or MEM producer stalls ID. The
    // register file writes before it reads, so a WB producer is harmless.
    assign w_raw   = w_id1_ex || w_id2_ex || w_id1_mem || w_id2_mem;
    assign w_fwd_a = 2'b00;
    assign w_fwd_b = 2'b00;

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{WBsel_EX, WBsel_MEM, rR1_EX, rR2_EX, wR_WB, RF_we_WB};
`endif

    assign w_hz_stall = w_raw && !w_mem_stall && !w_br_flush;

    // ------------------------------------------------------------------
    // Outputs: all forced low while reset is held
    // ------------------------------------------------------------------
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        fwdA_EX     = 2'b00;
        fwdB_EX     = 2'b00;
        mem_wait    = 1'b0;
        mem_err     = 1'b0;
        if (!rst_n) begin
            pc_stall    = w_mem_stall || w_hz_stall;
            ifid_stall  = w_mem_stall || w_hz_stall;
            idex_stall  = w_mem_stall;
            exmem_stall = w_mem_stall;
            memwb_flush = w_mem_stall;
            ifid_flush  = w_br_flush;
            idex_flush  = w_br_flush || w_hz_stall;
            fwdA_EX     = w_fwd_a;
            fwdB_EX     = w_fwd_b;
            mem_wait    = (state_q == C_ST_WAIT);
            mem_err     = mem_err_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl
//               with MEM_TIMEOUT=4. Expectations for forwarding-dependent
//               vectors follow `FORWARDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] rR1_ID = '0, rR2_ID = '0, rR1_EX = '0, rR2_EX = '0;
    logic       re1_ID = 1'b0, re2_ID = 1'b0;
    logic [4:0] wR_EX = '0, wR_MEM = '0, wR_WB = '0;
    logic       RF_we_EX = 1'b0, RF_we_MEM = 1'b0, RF_we_WB = 1'b0;
    logic [1:0] WBsel_EX = '0, WBsel_MEM = '0;
    logic       branch_taken_EX = 1'b0, Dram_req_MEM = 1'b0, Dram_ack = 1'b0;

    logic pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic ifid_flush, idex_flush, memwb_flush, mem_wait, mem_err;
    logic [1:0] fwdA_EX, fwdB_EX;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rR1_ID(rR1_ID), .rR2_ID(rR2_ID), .re1_ID(re1_ID), .re2_ID(re2_ID),
        .rR1_EX(rR1_EX), .rR2_EX(rR2_EX),
        .wR_EX(wR_EX), .RF_we_EX(RF_we_EX), .WBsel_EX(WBsel_EX),
        .wR_MEM(wR_MEM), .RF_we_MEM(RF_we_MEM), .WBsel_MEM(WBsel_MEM),
        .wR_WB(wR_WB), .RF_we_WB(RF_we_WB),
        .branch_taken_EX(branch_taken_EX),
        .Dram_req_MEM(Dram_req_MEM), .Dram_ack(Dram_ack),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .fwdA_EX(fwdA_EX), .fwdB_EX(fwdB_EX),
        .mem_wait(mem_wait), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Packed view {pc,ifid,idex,exmem stall, ifid,idex,memwb flush, wait, err}
    logic [8:0] w_out;
    assign w_out = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                    ifid_flush, idex_flush, memwb_flush, mem_wait, mem_err};

    localparam logic [8:0] C_NONE = 9'b0_0000_0000;
    localparam logic [8:0] C_MST  = 9'b1_1110_0100; // memory stall
    localparam logic [8:0] C_WT   = 9'b0_0000_0010; // mem_wait
    localparam logic [8:0] C_ERR  = 9'b0_0000_0001; // mem_err
    localparam logic [8:0] C_HZ   = 9'b1_1000_1000; // pc/ifid stall + idex flush
    localparam logic [8:0] C_BR   = 9'b0_0001_1000; // ifid + idex flush

`ifdef FORWARDING_EN
    localparam logic [8:0] C_HZ_NF = C_NONE; // producer-in-EX/MEM stall
    localparam logic [1:0] C_F01 = 2'b01, C_F10 = 2'b10, C_F11 = 2'b11;
`else
    localparam logic [8:0] C_HZ_NF = C_HZ;
    localparam logic [1:0] C_F01 = 2'b00, C_F10 = 2'b00, C_F11 = 2'b00;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the combinational outputs of the current cycle, then advance.
    task automatic cyc(input string tag, input logic [8:0] eo,
                       input logic [1:0] fa, input logic [1:0] fb);
        #1;
        check({tag, ".ctl"}, 16'(w_out), 16'(eo));
        check({tag, ".fA"},  16'(fwdA_EX), 16'(fa));
        check({tag, ".fB"},  16'(fwdB_EX), 16'(fb));
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rR1_ID = '0; rR2_ID = '0; re1_ID = 1'b0; re2_ID = 1'b0;
        rR1_EX = '0; rR2_EX = '0;
        wR_EX = '0; RF_we_EX = 1'b0; WBsel_EX = '0;
        wR_MEM = '0; RF_we_MEM = 1'b0; WBsel_MEM = '0;
        wR_WB = '0; RF_we_WB = 1'b0;
        branch_taken_EX = 1'b0; Dram_req_MEM = 1'b0; Dram_ack = 1'b0;
    endtask

    initial begin
        // Reset held with active inputs: every output low
        rst_n = 1'b1;
        Dram_req_MEM = 1'b1; branch_taken_EX = 1'b1;
        rR1_ID = 5'd3; re1_ID = 1'b1; wR_EX = 5'd3; RF_we_EX = 1'b1;
        @(posedge clk); #1;
        cyc("rst_hold", C_NONE, 2'b00, 2'b00);
        rst_n = 1'b0; clr();
        cyc("idle", C_NONE, 2'b00, 2'b00);

        // EX-operand forwarding
        clr(); wR_MEM = 5'd3; RF_we_MEM = 1'b1; WBsel_MEM = 2'b00; rR1_EX = 5'd3;
        cyc("fwd_alu", C_NONE, C_F01, 2'b00);
        clr(); wR_MEM = 5'd1; RF_we_MEM = 1'b1; WBsel_MEM = 2'b10; rR1_EX = 5'd1;
        cyc("fwd_jal", C_NONE, C_F10, 2'b00);
        clr(); wR_WB = 5'd7; RF_we_WB = 1'b1; rR1_EX = 5'd7; rR2_EX = 5'd7;
        cyc("fwd_wb", C_NONE, C_F11, C_F11);
        clr(); wR_WB = 5'd7; RF_we_WB = 1'b1; wR_MEM = 5'd7; RF_we_MEM = 1'b1;
        rR1_EX = 5'd7;
        cyc("fwd_prio", C_NONE, C_F01, 2'b00);
        clr(); wR_MEM = 5'd7; RF_we_MEM = 1'b0; rR2_EX = 5'd7;
        cyc("fwd_nowe", C_NONE, 2'b00, 2'b00);

        // Load-use: lw x5 in EX, ID reads x5 via rR2
        clr(); wR_EX = 5'd5; RF_we_EX = 1'b1; WBsel_EX = 2'b01;
        rR2_ID = 5'd5; re2_ID = 1'b1;
        cyc("lu_stall", C_HZ, 2'b00, 2'b00);
        clr(); wR_MEM = 5'd5; RF_we_MEM = 1'b1; WBsel_MEM = 2'b01;
        rR2_ID = 5'd5; re2_ID = 1'b1;
        cyc("lu_bubble", C_HZ_NF, 2'b00, 2'b00);
        clr(); wR_WB = 5'd5; RF_we_WB = 1'b1; rR2_EX = 5'd5;
        cyc("lu_fwd", C_NONE, 2'b00, C_F11);

        // Branch together with a load-use match: flush wins, no stall
        clr(); wR_EX = 5'd5; RF_we_EX = 1'b1; WBsel_EX = 2'b01;
        rR2_ID = 5'd5; re2_ID = 1'b1; branch_taken_EX = 1'b1;
        cyc("br_lu", C_BR, 2'b00, 2'b00);

        // x0 and disabled reads never hazard
        clr(); wR_EX = 5'd0; RF_we_EX = 1'b1; WBsel_EX = 2'b01;
        rR1_ID = 5'd0; re1_ID = 1'b1; wR_MEM = 5'd0; RF_we_MEM = 1'b1; rR1_EX = 5'd0;
        cyc("x0", C_NONE, 2'b00, 2'b00);
        clr(); wR_EX = 5'd5; RF_we_EX = 1'b1; WBsel_EX = 2'b01;
        rR1_ID = 5'd5; re1_ID = 1'b0;
        cyc("no_re", C_NONE, 2'b00, 2'b00);

        // add x3 then use: stalls 2 cycles without forwarding
        clr(); wR_EX = 5'd3; RF_we_EX = 1'b1; rR1_ID = 5'd3; re1_ID = 1'b1;
        cyc("raw_ex", C_HZ_NF, 2'b00, 2'b00);
        clr(); wR_MEM = 5'd3; RF_we_MEM = 1'b1; rR1_ID = 5'd3; re1_ID = 1'b1;
        cyc("raw_mem", C_HZ_NF, 2'b00, 2'b00);
        clr(); wR_WB = 5'd3; RF_we_WB = 1'b1; rR1_ID = 5'd3; re1_ID = 1'b1;
        cyc("raw_wb", C_NONE, 2'b00, 2'b00);

        // Ack in the same cycle as req: no stall
        clr(); Dram_req_MEM = 1'b1; Dram_ack = 1'b1;
        cyc("ack_same", C_NONE, 2'b00, 2'b00);

        // Ack 3 cycles after req, branch held frozen until release
        clr(); Dram_req_MEM = 1'b1; branch_taken_EX = 1'b1;
        cyc("dw_req", C_MST, 2'b00, 2'b00);
        cyc("dw_w1", C_MST | C_WT, 2'b00, 2'b00);
        cyc("dw_w2", C_MST | C_WT, 2'b00, 2'b00);
        Dram_ack = 1'b1;
        cyc("dw_ack", C_BR | C_WT, 2'b00, 2'b00);
        clr();
        cyc("dw_run", C_NONE, 2'b00, 2'b00);

        // Timeout with MEM_TIMEOUT=4: 5 stall cycles, then mem_err
        clr(); Dram_req_MEM = 1'b1;
        cyc("to_req", C_MST, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) cyc($sformatf("to_w%0d", i), C_MST | C_WT, 2'b00, 2'b00);
        clr();
        cyc("to_err", C_ERR, 2'b00, 2'b00);
        cyc("to_sticky", C_ERR, 2'b00, 2'b00);

        // Reset mid-wait clears state, counter and mem_err
        Dram_req_MEM = 1'b1;
        cyc("rw_req", C_MST | C_ERR, 2'b00, 2'b00);
        cyc("rw_w1", C_MST | C_WT | C_ERR, 2'b00, 2'b00);
        rst_n = 1'b1;
        cyc("rw_rst", C_NONE, 2'b00, 2'b00);
        rst_n = 1'b0; clr();
        cyc("rw_after", C_NONE, 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
